// File: rtl/key_event_sampler_if.sv
// Event handshake between the key sampler and its consumer.
// The consumer raises event_ready to take the pending one-hot key event.
interface key_event_sampler_if #(
   parameter int N_KEYS = 4
);
   logic              event_valid;
   logic              event_ready;
   logic [N_KEYS-1:0] event_key;
   logic              event_repeat;

   modport master (
      output event_valid,
      output event_key,
      output event_repeat,
      input  event_ready
   );

   modport slave (
      input  event_valid,
      input  event_key,
      input  event_repeat,
      output event_ready
   );
endinterface

// File: rtl/key_event_sampler.sv
// Synchronises and debounces raw key levels, then emits one-hot press events
// through a single-entry output register, with optional auto-repeat.
module key_event_sampler #(
   parameter int N_KEYS          = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_KEYS-1:0]   keys_in,
   key_event_sampler_if.master evt,
   output logic [N_KEYS-1:0]   held,
   output logic                overrun
);

   localparam int DB_W = 20;
   localparam int RP_W = 26;
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0]   RP_LAST  = RP_W'(REPEAT_CYCLES - 1);
   localparam logic [N_KEYS-1:0] POLARITY = (ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic {IDLE, ARMED} rep_state_t;

   logic [N_KEYS-1:0] sync_p0, sync_p1;
   logic [DB_W-1:0]   db_cnt [N_KEYS];
   logic [N_KEYS-1:0] settle, press, release_k, win;
   logic              any_press, extra_press;

   rep_state_t        state, state_nx;
   logic [N_KEYS-1:0] arm_key, arm_key_nx;
   logic [RP_W-1:0]   rep_cnt, rep_cnt_nx;
   logic              rep_fire;

   logic              busy, new_evt, load, discard, new_rep;
   logic [N_KEYS-1:0] new_key;

   // Stage p0/p1: polarity is folded in ahead of the flops so a cleared
   // synchroniser always reads as "released".
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= keys_in ^ POLARITY;
         sync_p1 <= sync_p0;
      end
   end

   always_comb begin
      for (int i = 0; i < N_KEYS; i++) begin
         settle[i] = (sync_p1[i] != held[i]) && (db_cnt[i] == DB_LAST);
      end
   end

   // Debounce stage: held toggles once a disagreement has lasted long enough.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         held <= '0;
         for (int i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            if ((sync_p1[i] == held[i]) || settle[i]) db_cnt[i] <= '0;
            else                                      db_cnt[i] <= db_cnt[i] + 1'b1;
            if (settle[i]) held[i] <= ~held[i];
         end
      end
   end

   always_comb begin
      press       = settle & sync_p1;
      release_k   = settle & ~sync_p1;
      win         = press & (-press);
      any_press   = |press;
      extra_press = |(press & ~win);
   end

   // Repeat FSM: state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         arm_key <= '0;
         rep_cnt <= '0;
      end else begin
         state   <= state_nx;
         arm_key <= arm_key_nx;
         rep_cnt <= rep_cnt_nx;
      end
   end

   // Repeat FSM: output; a fresh press or release of the armed key pre-empts a repeat
   always_comb begin
      rep_fire = (state == ARMED) && (|(held & arm_key)) && !any_press &&
                 !(|(release_k & arm_key)) && (rep_cnt == RP_LAST);
   end

   always_comb begin
      busy    = evt.event_valid && !evt.event_ready;
      new_evt = any_press || rep_fire;
      new_key = any_press ? win : arm_key;
      new_rep = !any_press;
      load    = new_evt && !busy;
      discard = (new_evt && busy) || extra_press;
   end

   // Repeat FSM: next state
   always_comb begin
      state_nx   = state;
      arm_key_nx = arm_key;
      rep_cnt_nx = rep_cnt;
      if (REPEAT_EN == 0) begin
         state_nx   = IDLE;
         arm_key_nx = '0;
         rep_cnt_nx = '0;
      end else if (any_press && load) begin
         state_nx   = ARMED;
         arm_key_nx = win;
         rep_cnt_nx = '0;
      end else if (state == ARMED) begin
         if (|(release_k & arm_key)) begin
            state_nx   = IDLE;
            arm_key_nx = '0;
            rep_cnt_nx = '0;
         end else if (any_press) begin
            rep_cnt_nx = '0;
         end else if (|(held & arm_key)) begin
            rep_cnt_nx = (rep_cnt == RP_LAST) ? '0 : rep_cnt + 1'b1;
         end
      end
   end

   // Output stage: single-entry event register and overrun pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         evt.event_valid  <= 1'b0;
         evt.event_key    <= '0;
         evt.event_repeat <= 1'b0;
         overrun          <= 1'b0;
      end else begin
         overrun <= discard;
         if (load) begin
            evt.event_valid  <= 1'b1;
            evt.event_key    <= new_key;
            evt.event_repeat <= new_rep;
         end else if (evt.event_valid && evt.event_ready) begin
            evt.event_valid  <= 1'b0;
            evt.event_key    <= '0;
            evt.event_repeat <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_key_event_sampler.sv
// Scoreboard bench: stimulus pushes expected events/overruns, a negedge
// monitor pops and compares them as the two sampler instances present them.
module tb_key_event_sampler;

   typedef struct {
      int         dut;
      logic [3:0] key;
      logic       rep;
      int         cyc;
   } ev_t;

   typedef struct {
      int dut;
      int cyc;
   } ov_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] keys0, keys1, held0, held1;
   logic       ov0, ov1, rdy0, rdy1;
   int         cyc = 0;
   int         n_pass = 0;
   int         n_total = 0;
   int         c;
   ev_t        eq[$];
   ov_t        oq[$];
   logic       pv[2];
   logic       pr[2];

   key_event_sampler_if #(.N_KEYS(4)) bus0 ();
   key_event_sampler_if #(.N_KEYS(4)) bus1 ();

   assign bus0.event_ready = rdy0;
   assign bus1.event_ready = rdy1;

   key_event_sampler #(
      .N_KEYS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_CYCLES(10)
   ) dut0 (
      .clock(clock), .reset(reset), .keys_in(keys0), .evt(bus0),
      .held(held0), .overrun(ov0)
   );

   key_event_sampler #(
      .N_KEYS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_CYCLES(10)
   ) dut1 (
      .clock(clock), .reset(reset), .keys_in(keys1), .evt(bus1),
      .held(held1), .overrun(ov1)
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_ev(input int d, input logic [3:0] k, input logic rp, input int at);
      ev_t e;
      e.dut = d; e.key = k; e.rep = rp; e.cyc = at;
      eq.push_back(e);
   endtask

   task automatic push_ov(input int d, input int at);
      ov_t o;
      o.dut = d; o.cyc = at;
      oq.push_back(o);
   endtask

   task automatic mon(input int d, input logic v, input logic [3:0] k, input logic rp,
                      input logic rdy, input logic ov);
      ev_t e;
      ov_t o;
      if (v && (!pv[d] || pr[d])) begin
         if (eq.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: dut%0d key=%b rep=%b at cycle %0d, none expected",
                     d, k, rp, cyc);
         end else begin
            e = eq.pop_front();
            check("event_dut", d, e.dut);
            check("event_key", {28'd0, k}, {28'd0, e.key});
            check("event_repeat", {31'd0, rp}, {31'd0, e.rep});
            check("event_cycle", cyc, e.cyc);
         end
      end
      if (ov) begin
         if (oq.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_overrun: dut%0d at cycle %0d, none expected", d, cyc);
         end else begin
            o = oq.pop_front();
            check("overrun_dut", d, o.dut);
            check("overrun_cycle", cyc, o.cyc);
         end
      end
      pv[d] = v;
      pr[d] = rdy;
   endtask

   initial begin
      pv[0] = 1'b0; pv[1] = 1'b0; pr[0] = 1'b0; pr[1] = 1'b0;
      forever begin
         @(negedge clock);
         mon(0, bus0.event_valid, bus0.event_key, bus0.event_repeat, rdy0, ov0);
         mon(1, bus1.event_valid, bus1.event_key, bus1.event_repeat, rdy1, ov1);
      end
   end

   initial begin
      reset = 1'b1; keys0 = 4'hF; keys1 = 4'hF; rdy0 = 1'b1; rdy1 = 1'b1;
      #2;
      check("rst_held0", held0, 0);
      check("rst_valid0", bus0.event_valid, 0);
      check("rst_key0", bus0.event_key, 0);
      check("rst_overrun0", ov0, 0);
      check("rst_held1", held1, 0);
      check("rst_valid1", bus1.event_valid, 0);
      tick(2);
      reset = 1'b0;
      tick(8);
      check("idle_held", held0, 0);

      // basic press of key0
      keys0 = 4'b1110; c = cyc; push_ev(0, 4'b0001, 1'b0, c + 6);
      tick(5);
      check("basic_held_early", held0, 0);
      tick(1);
      check("basic_held", held0, 4'b0001);
      check("basic_valid", bus0.event_valid, 1);
      tick(1);
      check("basic_valid_drop", bus0.event_valid, 0);
      keys0 = 4'hF;
      tick(8);
      check("basic_release", held0, 0);

      // bounce on key0 never outlasts the debounce window
      for (int i = 0; i < 10; i++) begin
         keys0 = (i % 2 == 0) ? 4'b1110 : 4'b1111;
         tick(2);
      end
      keys0 = 4'hF;
      tick(10);
      check("bounce_held", held0, 0);

      // keys 1 and 3 together: key1 wins, key3 overruns
      keys0 = 4'b0101; c = cyc;
      push_ev(0, 4'b0010, 1'b0, c + 6); push_ov(0, c + 6);
      tick(6);
      check("simul_held", held0, 4'b1010);
      keys0 = 4'hF;
      tick(10);

      // backpressure
      rdy0 = 1'b0;
      keys0 = 4'b1110; c = cyc; push_ev(0, 4'b0001, 1'b0, c + 6);
      tick(8);
      keys0 = 4'hF;
      tick(8);
      check("bp_release_held", held0, 0);
      keys0 = 4'b1011; c = cyc; push_ov(0, c + 6);
      tick(7);
      check("bp_key_hold", bus0.event_key, 4'b0001);
      check("bp_valid_hold", bus0.event_valid, 1);
      check("bp_held", held0, 4'b0100);
      rdy0 = 1'b1;
      tick(1);
      check("bp_valid_drop", bus0.event_valid, 0);
      keys0 = 4'hF;
      tick(10);

      // auto-repeat on key3
      keys1 = 4'b0111; c = cyc;
      push_ev(1, 4'b1000, 1'b0, c + 6);
      push_ev(1, 4'b1000, 1'b1, c + 16);
      push_ev(1, 4'b1000, 1'b1, c + 26);
      push_ev(1, 4'b1000, 1'b1, c + 36);
      tick(38);
      keys1 = 4'hF;
      tick(30);
      check("rep_released", held1, 0);

      // reset between edges while key1 is held
      rdy0 = 1'b0;
      keys0 = 4'b1101; c = cyc; push_ev(0, 4'b0010, 1'b0, c + 6);
      tick(8);
      check("mid_held", held0, 4'b0010);
      check("mid_valid", bus0.event_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_held", held0, 0);
      check("mid_rst_valid", bus0.event_valid, 0);
      check("mid_rst_key", bus0.event_key, 0);
      tick(2);
      reset = 1'b0; rdy0 = 1'b1; c = cyc;
      push_ev(0, 4'b0010, 1'b0, c + 6);
      tick(6);
      check("post_rst_held", held0, 4'b0010);
      keys0 = 4'hF;
      tick(10);

      check("events_drained", eq.size(), 0);
      check("overruns_drained", oq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
